// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings, data-phase state codes and byte-lane decode
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_WSTALL = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        return size == HSIZE_BYTE ? 4'b0001 << lane :
               size == HSIZE_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

endpackage

// File: rtl/ahbl_excl_monitor.sv
// ahbl_excl_monitor: one reservation (valid + word address) per master ID
module ahbl_excl_monitor #(
    parameter int N_MASTERS = 2,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic [7:0]    set_master,
    input  logic [AW-1:0] set_addr,
    input  logic [7:0]    chk_master,
    input  logic [AW-1:0] chk_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    output logic          match
);

    logic [N_MASTERS-1:0] valid_q, valid_d;
    logic [AW-1:0]        addr_q [N_MASTERS];
    logic [AW-1:0]        addr_d [N_MASTERS];

    // Drop reservations hit by a performed write, record new ones, look up the checker's entry
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        match   = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (clr_en && valid_q[i] && addr_q[i] == clr_addr) valid_d[i] = 1'b0;
            if (set_en && set_master == 8'(i)) begin
                valid_d[i] = 1'b1;
                addr_d[i]  = set_addr;
            end
            if (chk_master == 8'(i) && valid_q[i] && addr_q[i] == chk_addr) match = 1'b1;
        end
    end

    // Reservation table; reset invalidates every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/ahbl_sram_excl.sv
// ahbl_sram_excl: zero-wait AHB-Lite SRAM responder with an exclusive-access monitor
module ahbl_sram_excl
    import ahbl_pkg::*;
#(
    parameter int W_ADDR    = 32,
    parameter int W_DATA    = 32,
    parameter int DEPTH     = 1024,
    parameter int N_MASTERS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ahbls_hready,
    output logic                       ahbls_hready_resp,
    output logic                       ahbls_hresp,
    input  logic [W_ADDR-1:0]          ahbls_haddr,
    input  logic                       ahbls_hwrite,
    input  logic [1:0]                 ahbls_htrans,
    input  logic [2:0]                 ahbls_hsize,
    input  logic [2:0]                 ahbls_hburst,
    input  logic [3:0]                 ahbls_hprot,
    input  logic                       ahbls_hmastlock,
    input  logic [W_DATA-1:0]          ahbls_hwdata,
    output logic [W_DATA-1:0]          ahbls_hrdata,
    input  logic                       ahbls_hexcl,
    input  logic [7:0]                 ahbls_hmaster,
    output logic                       ahbls_hexokay,
    output logic [$clog2(DEPTH)-1:0]   sram_addr,
    output logic                       sram_cs,
    output logic                       sram_we,
    output logic [W_DATA/8-1:0]        sram_wbe,
    output logic [W_DATA-1:0]          sram_wdata,
    input  logic [W_DATA-1:0]          sram_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    wbe_q, wbe_d;
    logic          excl_q, excl_d;
    logic [7:0]    master_q, master_d;
    logic          wr_ok_q, wr_ok_d;
    logic          stall, acc, err, do_write, set_en, match;
    logic          unused_ok;

    assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

    // Address-phase decode, data-phase sequencing and bus/SRAM output drive
    always_comb begin
        stall    = state_q == S_WRITE && ahbls_htrans[1] && !ahbls_hwrite;
        acc      = ahbls_hready && ahbls_htrans[1] && !stall && state_q != S_ERR1;
        err      = ahbls_hsize > HSIZE_WORD
                   || (ahbls_hsize == HSIZE_HALF && ahbls_haddr[0])
                   || (ahbls_hsize == HSIZE_WORD && |ahbls_haddr[1:0])
                   || |ahbls_haddr[W_ADDR-1:AW+2];
        do_write = state_q == S_WRITE && (!excl_q || match);
        set_en   = acc && !err && !ahbls_hwrite && ahbls_hexcl;
        state_d  = state_q == S_ERR1 ? S_ERR2 :
                   stall             ? S_WSTALL :
                   !acc              ? S_IDLE :
                   err               ? S_ERR1 :
                   ahbls_hwrite      ? S_WRITE : S_READ;
        addr_d   = acc ? ahbls_haddr[AW+1:2] : addr_q;
        wbe_d    = acc ? byte_en(ahbls_hsize, ahbls_haddr[1:0]) : wbe_q;
        excl_d   = acc ? ahbls_hexcl && (ahbls_hwrite || int'(ahbls_hmaster) < N_MASTERS) : excl_q;
        master_d = acc ? ahbls_hmaster : master_q;
        wr_ok_d  = state_q == S_WRITE && excl_q && match;
        ahbls_hready_resp = !(state_q == S_ERR1 || stall);
        ahbls_hresp       = state_q == S_ERR1 || state_q == S_ERR2;
        ahbls_hexokay     = (excl_q && (state_q == S_READ || (state_q == S_WRITE && match)))
                            || (state_q == S_WSTALL && wr_ok_q);
        ahbls_hrdata      = sram_rdata;
        sram_cs           = rst_n && (do_write || (acc && !err && !ahbls_hwrite));
        sram_we           = do_write;
        sram_addr         = state_q == S_WRITE ? addr_q : ahbls_haddr[AW+1:2];
        sram_wbe          = wbe_q;
        sram_wdata        = ahbls_hwdata;
    end

    // Data-phase registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wbe_q    <= '0;
            excl_q   <= 1'b0;
            master_q <= '0;
            wr_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wbe_q    <= wbe_d;
            excl_q   <= excl_d;
            master_q <= master_d;
            wr_ok_q  <= wr_ok_d;
        end
    end

    ahbl_excl_monitor #(.N_MASTERS(N_MASTERS), .AW(AW)) u_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (set_en),
        .set_master (ahbls_hmaster),
        .set_addr   (ahbls_haddr[AW+1:2]),
        .chk_master (master_q),
        .chk_addr   (addr_q),
        .clr_en     (do_write),
        .clr_addr   (addr_q),
        .match      (match)
    );

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// tb_ahbl_sram_excl: directed vector table, reset-in-WSTALL sequence and random traffic vs a reference model
module tb_ahbl_sram_excl;

    localparam int DEPTH = 1024;
    localparam int NM    = 2;

    typedef struct {
        logic        write;
        logic        excl;
        logic [7:0]  master;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        err;
        logic        ok;
        logic        perf;
        logic [31:0] rdata;
        logic [3:0]  wbe;
        int          waits;
    } op_t;

    logic        clk = 0, rst_n = 0;
    logic        hready, hready_resp, hresp, hwrite = 0, hexcl = 0, hexokay, hmastlock = 0;
    logic [31:0] haddr = 0, hwdata = 0, hrdata;
    logic [1:0]  htrans = 0;
    logic [2:0]  hsize = 0, hburst = 0;
    logic [3:0]  hprot = 0;
    logic [7:0]  hmaster = 0;
    logic [9:0]  sram_addr;
    logic        sram_cs, sram_we, sram_clr = 0;
    logic [3:0]  sram_wbe;
    logic [31:0] sram_wdata, sram_rdata = 0;

    logic [31:0] sram [DEPTH];
    logic [7:0]  mem_b [4*DEPTH];
    int          res [NM];
    op_t         ops [$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign hready = hready_resp;

    ahbl_sram_excl dut (
        .clk(clk), .rst_n(rst_n), .ahbls_hready(hready), .ahbls_hready_resp(hready_resp),
        .ahbls_hresp(hresp), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
        .ahbls_hsize(hsize), .ahbls_hburst(hburst), .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata), .ahbls_hexcl(hexcl), .ahbls_hmaster(hmaster),
        .ahbls_hexokay(hexokay), .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_wbe(sram_wbe), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_clr) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= 32'h0;
        end else if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) if (sram_wbe[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else sram_rdata <= sram[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic w, input logic e, input logic [7:0] m, input logic [31:0] a,
                               input logic [2:0] s, input logic [31:0] d, input logic er, input logic ok,
                               input logic pf, input logic [31:0] rd, input logic [3:0] be, input int wt);
        op_t o;
        o.write = w; o.excl = e; o.master = m; o.addr = a; o.size = s; o.wdata = d;
        o.err = er; o.ok = ok; o.perf = pf; o.rdata = rd; o.wbe = be; o.waits = wt;
        return o;
    endfunction

    // Sequential view of the memory: transfers take effect one after another in bus order
    function automatic void model(inout op_t o);
        int a = int'(o.addr);
        int w = a / 4;
        int lane = a % 4;
        int nb = 1 << o.size;
        o.err = o.size > 2 || a % nb != 0 || a >= 4 * DEPTH;
        o.ok = 0; o.perf = 0; o.rdata = 0; o.wbe = 0;
        if (o.err) return;
        if (!o.write) begin
            for (int b = 0; b < 4; b++) o.rdata[8*b +: 8] = mem_b[4*w + b];
            o.ok = o.excl && o.master < NM;
            if (o.ok) res[o.master] = w;
        end else begin
            o.perf = !o.excl || (o.master < NM && res[o.master] == w);
            o.ok = o.excl && o.perf;
            if (o.perf) begin
                for (int k = 0; k < nb; k++) begin
                    mem_b[4*w + lane + k] = o.wdata[8*(lane + k) +: 8];
                    o.wbe[lane + k] = 1'b1;
                end
                for (int m = 0; m < NM; m++) if (res[m] == w) res[m] = -1;
            end
        end
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " hready_resp"}, hready_resp, 1);
        chk({tag, " hresp"}, hresp, 0);
        chk({tag, " hexokay"}, hexokay, 0);
        chk({tag, " sram_cs"}, sram_cs, 0);
        chk({tag, " sram_we"}, sram_we, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; htrans = 2'b10; hwrite = 0; haddr = 0; hsize = 2; hexcl = 0; sram_clr = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        sram_clr = 0; htrans = 2'b00; rst_n = 1;
        for (int i = 0; i < 4 * DEPTH; i++) mem_b[i] = 8'h0;
        for (int m = 0; m < NM; m++) res[m] = -1;
    endtask

    // Issue the queued transfers back-to-back and check each data phase as it completes
    task automatic run_ops();
        int a = 0, dp = -1, waits = 0, cyc = 0;
        bit first = 0;
        while ((a < ops.size() || dp >= 0) && cyc < 20000) begin
            bit wr_now;
            cyc++;
            if (a < ops.size()) begin
                htrans = 2'b10; hwrite = ops[a].write; hexcl = ops[a].excl;
                hmaster = ops[a].master; haddr = ops[a].addr; hsize = ops[a].size;
            end else htrans = 2'b00;
            hwdata = dp >= 0 ? ops[dp].wdata : 32'h0;
            @(negedge clk);
            wr_now = 0;
            if (dp >= 0) begin
                wr_now = first && ops[dp].write && !ops[dp].err && ops[dp].perf;
                if (first && ops[dp].write && !ops[dp].err) begin
                    chk($sformatf("op%0d sram_we", dp), sram_we, ops[dp].perf);
                    if (ops[dp].perf) chk($sformatf("op%0d sram_wbe", dp), sram_wbe, ops[dp].wbe);
                end
                if (hresp && !hready_resp) chk($sformatf("op%0d err1 sram_cs", dp), sram_cs, 0);
                first = 0;
                if (hready_resp) begin
                    chk($sformatf("op%0d waits", dp), waits, ops[dp].waits);
                    chk($sformatf("op%0d hresp", dp), hresp, ops[dp].err);
                    if (!ops[dp].err) chk($sformatf("op%0d hexokay", dp), hexokay, ops[dp].ok);
                    if (!ops[dp].err && !ops[dp].write) chk($sformatf("op%0d hrdata", dp), hrdata, ops[dp].rdata);
                    dp = -1;
                end else waits++;
            end
            if (hready_resp && a < ops.size()) begin
                if (ops[a].err && !wr_now) chk($sformatf("op%0d err accept sram_cs", a), sram_cs, 0);
                dp = a; a++; first = 1; waits = 0;
            end
            @(posedge clk);
            #1;
        end
        if (cyc >= 20000) chk("run_ops cycle budget", 1, 0);
        htrans = 2'b00;
        ops.delete();
    endtask

    initial begin
        op_t vec [18];
        vec[0]  = mk(1, 0, 0, 'h10,   2, 'hDEADBEEF, 0, 0, 1, 0,          'hF, 1);
        vec[1]  = mk(0, 0, 0, 'h10,   2, 0,          0, 0, 0, 'hDEADBEEF, 0,   0);
        vec[2]  = mk(1, 0, 0, 'h13,   0, 'hAA000000, 0, 0, 1, 0,          'h8, 1);
        vec[3]  = mk(0, 0, 0, 'h10,   2, 0,          0, 0, 0, 'hAAADBEEF, 0,   0);
        vec[4]  = mk(0, 1, 0, 'h20,   2, 0,          0, 1, 0, 0,          0,   0);
        vec[5]  = mk(1, 1, 0, 'h20,   2, 5,          0, 1, 1, 0,          'hF, 0);
        vec[6]  = mk(1, 1, 0, 'h20,   2, 6,          0, 0, 0, 0,          0,   1);
        vec[7]  = mk(0, 0, 0, 'h20,   2, 0,          0, 0, 0, 5,          0,   0);
        vec[8]  = mk(0, 1, 0, 'h20,   2, 0,          0, 1, 0, 5,          0,   0);
        vec[9]  = mk(1, 0, 1, 'h20,   2, 7,          0, 0, 1, 0,          'hF, 0);
        vec[10] = mk(1, 1, 0, 'h20,   2, 9,          0, 0, 0, 0,          0,   1);
        vec[11] = mk(0, 0, 0, 'h20,   2, 0,          0, 0, 0, 7,          0,   0);
        vec[12] = mk(0, 1, 5, 'h20,   2, 0,          0, 0, 0, 7,          0,   0);
        vec[13] = mk(1, 1, 5, 'h20,   2, 'h11,       0, 0, 0, 0,          0,   1);
        vec[14] = mk(0, 0, 0, 'h1000, 2, 0,          1, 0, 0, 0,          0,   1);
        vec[15] = mk(0, 0, 0, 'h0,    3, 0,          1, 0, 0, 0,          0,   1);
        vec[16] = mk(0, 0, 0, 'h1,    1, 0,          1, 0, 0, 0,          0,   1);
        vec[17] = mk(0, 0, 0, 'h20,   2, 0,          0, 0, 0, 7,          0,   0);
        do_reset();
        for (int i = 0; i < 18; i++) ops.push_back(vec[i]);
        run_ops();

        do_reset();
        ops.push_back(mk(0, 1, 0, 'h40, 2, 0, 0, 1, 0, 0, 0, 0));
        run_ops();
        htrans = 2'b10; hwrite = 1; hexcl = 0; hmaster = 1; haddr = 'h44; hsize = 2;
        @(posedge clk);
        #1;
        hwrite = 0; hwdata = 32'h1234;
        @(negedge clk);
        chk("stall hready_resp", hready_resp, 0);
        chk("stall sram_we", sram_we, 1);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk_reset("wstall reset");
        htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        ops.push_back(mk(1, 1, 0, 'h40, 2, 'h99, 0, 0, 0, 0, 0, 1));
        ops.push_back(mk(0, 0, 0, 'h40, 2, 0,    0, 0, 0, 0, 0, 0));
        ops.push_back(mk(0, 0, 0, 'h44, 2, 0,    0, 0, 0, 'h1234, 0, 0));
        run_ops();

        do_reset();
        for (int i = 0; i < 400; i++) begin
            op_t o;
            int r = $urandom_range(0, 19);
            o.write  = 1'($urandom_range(0, 1));
            o.excl   = 1'($urandom_range(0, 1));
            o.master = 8'($urandom_range(0, 2));
            o.size   = r == 0 ? 3'd3 : 3'($urandom_range(0, 2));
            o.addr   = r == 1 ? 32'(4 * DEPTH + 4 * $urandom_range(0, 3))
                              : 32'(4 * $urandom_range(0, 7) + $urandom_range(0, 3));
            o.wdata  = $urandom;
            model(o);
            ops.push_back(o);
        end
        for (int i = 0; i < ops.size(); i++)
            ops[i].waits = ops[i].err ? 1 : (ops[i].write && i + 1 < ops.size() && !ops[i+1].write) ? 1 : 0;
        run_ops();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_excl.md
# ahbl_sram_excl

AHB-Lite subordinate (responder) that fronts a single-port synchronous SRAM and implements the exclusive-access monitor answering `hexcl`/`hmaster` with `hexokay`. It sits on the downstream port of the strict-priority N:1 arbiter and closes the exclusive-access loop for multi-hart LR/SC traffic. Reads are zero-wait. Writes are zero-wait unless immediately followed by a read.

## Interface
Parameters:
- `W_ADDR`, 32: address width.
- `W_DATA`, 32: data width. Only 32 is supported.
- `DEPTH`, 1024: SRAM depth in words. Must be a power of 2.
- `N_MASTERS`, 2: reservation-table entries, indexed by `hmaster`.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ahbls_hready`  in  1: bus-level HREADY.
- `ahbls_hready_resp`  out  1: this slave's HREADYOUT.
- `ahbls_hresp`  out  1: 1 = ERROR.
- `ahbls_haddr`  in  W_ADDR: address.
- `ahbls_hwrite`  in  1: write.
- `ahbls_htrans`  in  2: transfer type.
- `ahbls_hsize`  in  3: transfer size.
- `ahbls_hburst`  in  3: ignored.
- `ahbls_hprot`  in  4: ignored.
- `ahbls_hmastlock`  in  1: ignored.
- `ahbls_hwdata`  in  W_DATA: write data, valid in data phase.
- `ahbls_hrdata`  out  W_DATA: read data.
- `ahbls_hexcl`  in  1: exclusive transfer.
- `ahbls_hmaster`  in  8: master ID.
- `ahbls_hexokay`  out  1: exclusive success, data phase.
- `sram_addr`  out  log2(DEPTH): word address.
- `sram_cs`  out  1: chip select.
- `sram_we`  out  1: write enable.
- `sram_wbe`  out  W_DATA/8: byte enables.
- `sram_wdata`  out  W_DATA: write data.
- `sram_rdata`  in  W_DATA: read data, one cycle after `cs & !we`.

## Operation
- **Address-phase accept**: `hready & htrans[1]`. On accept, register addr, size, write, excl and master into the data-phase registers.
- **Error on accept**: any of the following is an ERROR with no SRAM access and no reservation change:
  - `hsize > 2`;
  - address misaligned to `hsize`;
  - word index ≥ DEPTH.
- **Byte enables**: decoded from `hsize` and `haddr[1:0]`. Byte = 1 lane, half = 2 lanes, word = all 4 lanes.
- **Data-phase FSM states**: IDLE, READ, WRITE, WSTALL, ERR1, ERR2.
  - Accepted read → READ. SRAM read is issued in the accept cycle; `hrdata = sram_rdata` in READ.
  - Accepted write → WRITE. SRAM write is issued in the WRITE cycle using `hwdata`.
  - WRITE with a read being accepted in the same cycle → `hready_resp = 0`, go to WSTALL. In WSTALL the SRAM is idle and the held read is issued; `hready_resp = 1`; then go to READ.
  - Error → ERR1 (`hready_resp = 0`, `hresp = 1`) → ERR2 (`hready_resp = 1`, `hresp = 1`) → next phase.
  - IDLE/BUSY, or no accept → IDLE with an OKAY zero-wait response.
- **Exclusive monitor**: one entry per master ID (valid bit + word address).
  - Exclusive read, master in range: set entry[master] to the word address in the SRAM issue cycle. `hexokay = 1` in READ.
  - Exclusive write: succeeds iff entry[master] is valid and its address matches. On success, perform the write and drive `hexokay = 1`. On failure, hold `sram_we = 0` (write suppressed) and drive `hexokay = 0` with an OKAY response.
  - Every performed write, exclusive or not, clears all entries matching its word address, including the writer's own.
  - `hmaster ≥ N_MASTERS`: exclusive reads set nothing and return `hexokay = 0`; exclusive writes always fail.
  - Non-exclusive transfers: `hexokay = 0`.
- **Reset values**: `hready_resp = 1`, `hresp = 0`, `hexokay = 0`, `sram_cs = 0`, `sram_we = 0`. All reservations invalid; FSM in IDLE.
- **Reset mid-transfer**: aborts the transfer. The SRAM is not written after `rst_n` falls.

## Timing
- Read: accept at cycle N, data and OKAY at N+1.
- Write: accept at N, SRAM write and OKAY at N+1.
- Write followed by read: write data phase is 2 cycles; read data arrives at N+3 relative to the write accept.
- Error: 2-cycle data phase.
- Set/clear collision on one entry cannot occur: WSTALL orders the write before the read. The read therefore observes the new data and sets its reservation afterwards.
- `hexokay` and `hresp` are meaningful only while `hready_resp = 1`, except in ERR1.

## Structure
- Shared package `ahbl_pkg`: HTRANS encodings (IDLE, BUSY, NSEQ, SEQ), HSIZE encodings, FSM state enum.
- Sub-module `ahbl_excl_monitor`:
  - Inputs: set request (master, addr), check request (master, addr), clear-on-write (addr).
  - Output: match.
  - Purely sequential table with combinational lookup.

## Test plan
- Word write 0xDEADBEEF @0x10, then read @0x10 → OKAY zero-wait; `hrdata = 0xDEADBEEF`.
- Byte write 0xAA @0x13 → `sram_wbe = 4'b1000`; read-after-write inserts exactly 1 wait cycle; read returns 0xAA in byte 3.
- Master 0: exclusive read @0x20, then exclusive write 0x5 → `hexokay = 1`, memory = 5. Repeat the exclusive write → `hexokay = 0`, memory unchanged.
- Master 0 exclusive read @0x20; master 1 plain write 0x7 @0x20; master 0 exclusive write 0x9 → `hexokay = 0`, memory = 7.
- Address 4*DEPTH, or `hsize = 3`, or halfword @0x1 → ERR1/ERR2 sequence, `sram_cs = 0` throughout.
- Assert `rst_n` during WSTALL → outputs return to reset values immediately; a prior exclusive read's reservation is invalid afterwards.
